dmem_store_buf: RTL and testbench
=================================

Name: dmem_store_buf

Overview:
- Data-memory stage directly downstream of the STRV32I core's dm_* port; takes core loads and stores and returns load data.
- Contains a word-addressed RAM behind an SB_DEPTH-entry store buffer, with byte-lane write masks.
- Stores are queued and drained into the RAM on cycles when the RAM port is free. Loads are merged with pending stores.
- Replaces the behavioural data-memory model in the core bench.

Parameters:
- MEM_WORDS, 128, number of 32-bit RAM words.
- SB_DEPTH, 4, store buffer entries (power of 2, at least 2).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- dm_addr  in  32  byte address from the core; bits [1:0] ignored; word index = dm_addr[31:2].
- dm_data_out  in  32  store data from the core.
- dm_wr_mask  in  4  byte-lane enables; bit n covers bits [8n+7:8n].
- dm_wr_req  in  1  store request.
- dm_rd_req  in  1  load request.
- dm_data_in  out  32  registered load data to the core.
- dm_stall  out  1  combinational; core must hold its request while high.
- dm_err  out  1  registered one-cycle pulse on an out-of-range access.

Behaviour:
- Reset (rst low, asynchronous):
  - head, tail and count clear to 0.
  - dm_data_in = 0, dm_err = 0.
  - RAM contents are not reset.
- Reset released mid-operation: all buffered stores are lost; the bench treats RAM contents as unknown.
- Range: an address is out of range when its word index is >= MEM_WORDS.
- Store accept: dm_wr_req high and dm_stall low.
  - In range: push {word index, data, mask} at tail.
  - Out of range: nothing is pushed; dm_err = 1 next cycle.
  - A mask of 4'b0000 is accepted and occupies an entry; it writes nothing when drained.
- dm_stall when full: dm_stall = 1 while count == SB_DEPTH.
  - A store presented while full is not accepted, even if an entry drains in the same cycle.
  - It is accepted on the first cycle dm_stall is low.
- Drain:
  - Drain occurs when count > 0 and dm_rd_req is low (single RAM port).
  - The head entry writes its masked bytes into RAM, then head advances.
  - At most one drain per cycle.
- Push and drain in the same cycle: count unchanged. Pointers wrap modulo SB_DEPTH.
- Load accept: dm_rd_req high and dm_stall low.
  - Next cycle dm_data_in = RAM word with pending stores merged per byte.
  - For each byte, the youngest matching buffer entry with that mask bit set wins.
  - Out-of-range load: dm_data_in = 0 next cycle and dm_err = 1.
  - Load latency is exactly 1 cycle.
  - dm_data_in holds its value on cycles with no accepted load.
- Load and store in the same cycle: the load sees buffer state from before this cycle's push. It does not see the store presented with it.
- dm_err: high for exactly one cycle per offending access. Two consecutive offending accesses keep it high for two cycles.
- Empty buffer: loads read the RAM directly; nothing drains.

Optional Feature:
- Macro: DMEM_SB_FWD_EN.
- Defined: loads are merged with pending stores as described under Load accept; a load never stalls for a buffer hit.
- Undefined: no store-to-load merging.
  - A load whose word index matches any valid entry raises dm_stall.
  - While such a load stalls, the drain takes the RAM port despite dm_rd_req being high.
  - dm_stall drops in the cycle after the last matching entry drains; the load then completes from RAM with 1-cycle latency.

Test Plan:
- Reset check: hold rst low 2 cycles, then release → dm_data_in = 0, dm_err = 0, dm_stall = 0.
- Store then immediate load:
  - Stimulus: store 0xDEADBEEF mask 4'hF to 0x40, next cycle load 0x40.
  - Required: dm_data_in = 0xDEADBEEF one cycle later (without the macro: 1-cycle stall first). Load 0x40 again after 2 idle cycles → 0xDEADBEEF from RAM.
- Byte merge across entries:
  - Stimulus: store 0x11223344 mask F to 0x08, then 0xAAxxxxBB mask 4'b1001 to 0x08, load 0x08 before any drain.
  - Required: dm_data_in = 0xAA2233BB.
- Full boundary:
  - Stimulus: hold dm_rd_req high (load 0x0), issue 5 stores.
  - Required: 4 accepted; dm_stall high on the 5th. Drop dm_rd_req → one drain; 5th store accepted the following cycle; count = 4.
- Out of range: store to 0x200 (word 128) → not enqueued, dm_err pulses 1 cycle; load 0x200 → dm_data_in = 0, dm_err pulses.
- Reset mid-drain: 3 entries pending, assert rst → count = 0, dm_stall = 0, dm_data_in = 0 immediately (asynchronous).

Source files
------------

// File: rtl/dmem_store_buf_if.sv
// Core-side data-memory bus between the STRV32I dm_* port and the store-buffered RAM.
// master = core side, slave = memory stage.
interface dmem_store_buf_if;
    logic [31:0] dm_addr;
    logic [31:0] dm_data_out;
    logic [3:0]  dm_wr_mask;
    logic        dm_wr_req;
    logic        dm_rd_req;
    logic [31:0] dm_data_in;
    logic        dm_stall;
    logic        dm_err;

    modport master (
        output dm_addr, dm_data_out, dm_wr_mask, dm_wr_req, dm_rd_req,
        input  dm_data_in, dm_stall, dm_err
    );

    modport slave (
        input  dm_addr, dm_data_out, dm_wr_mask, dm_wr_req, dm_rd_req,
        output dm_data_in, dm_stall, dm_err
    );
endinterface

// File: rtl/dmem_store_buf.sv
// Data-memory stage: word RAM behind an SB_DEPTH-entry store buffer with byte-lane masks.
// Define DMEM_SB_FWD_EN to merge pending stores into loads; otherwise a load hitting the buffer stalls until it drains.
module dmem_store_buf #(
    parameter int MEM_WORDS = 128,
    parameter int SB_DEPTH  = 4
) (
    input logic             clk,
    input logic             rst,
    dmem_store_buf_if.slave dm
);
    localparam int PTR_W = $clog2(SB_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int IDX_W = $clog2(MEM_WORDS);

    logic [31:0]      r_mem     [MEM_WORDS];
    logic [IDX_W-1:0] r_sb_idx  [SB_DEPTH];
    logic [31:0]      r_sb_data [SB_DEPTH];
    logic [3:0]       r_sb_mask [SB_DEPTH];
    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [CNT_W-1:0] r_count;
    logic [31:0]      r_data_in;
    logic             r_err;

    logic [29:0]      w_word;
    logic [IDX_W-1:0] w_idx;
    logic             w_oor;
    logic             w_full;
    logic             w_stall;
    logic             w_ld_acc;
    logic             w_st_acc;
    logic             w_push;
    logic             w_drain;
    logic [31:0]      w_ld_data;
    logic             w_unused;

    assign w_word   = dm.dm_addr[31:2];
    assign w_idx    = w_word[IDX_W-1:0];
    assign w_oor    = w_word >= 30'(MEM_WORDS);
    assign w_full   = r_count == CNT_W'(SB_DEPTH);
    assign w_unused = ^dm.dm_addr[1:0];

`ifdef DMEM_SB_FWD_EN
    always_comb begin
        w_ld_data = r_mem[w_idx];
        // oldest to youngest, so the youngest entry owning a byte wins
        for (int i = 0; i < SB_DEPTH; i++) begin
            if (CNT_W'(i) < r_count && r_sb_idx[r_head + PTR_W'(i)] == w_idx) begin
                for (int b = 0; b < 4; b++) begin
                    if (r_sb_mask[r_head + PTR_W'(i)][b])
                        w_ld_data[8*b +: 8] = r_sb_data[r_head + PTR_W'(i)][8*b +: 8];
                end
            end
        end
    end

    assign w_stall = w_full;
    assign w_drain = (r_count != '0) && !dm.dm_rd_req;
`else
    logic w_hit;
    logic w_ld_hit;

    always_comb begin
        w_hit = 1'b0;
        for (int i = 0; i < SB_DEPTH; i++) begin
            if (CNT_W'(i) < r_count && r_sb_idx[r_head + PTR_W'(i)] == w_idx)
                w_hit = 1'b1;
        end
    end

    assign w_ld_hit  = dm.dm_rd_req && !w_oor && w_hit;
    assign w_ld_data = r_mem[w_idx];
    assign w_stall   = w_full || w_ld_hit;
    // a load held off by a buffer hit leaves the RAM port free for draining
    assign w_drain   = (r_count != '0) && (!dm.dm_rd_req || w_ld_hit);
`endif

    assign w_ld_acc = dm.dm_rd_req && !w_stall;
    assign w_st_acc = dm.dm_wr_req && !w_stall;
    assign w_push   = w_st_acc && !w_oor;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_head    <= '0;
            r_tail    <= '0;
            r_count   <= '0;
            r_data_in <= '0;
            r_err     <= 1'b0;
        end else begin
            if (w_push)
                r_tail <= r_tail + PTR_W'(1);
            if (w_drain)
                r_head <= r_head + PTR_W'(1);
            r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_drain);
            if (w_ld_acc)
                r_data_in <= w_oor ? 32'h0 : w_ld_data;
            r_err <= (w_ld_acc || w_st_acc) && w_oor;
        end
    end

    // buffer payload and RAM contents carry no reset
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_sb_idx[r_tail]  <= w_idx;
            r_sb_data[r_tail] <= dm.dm_data_out;
            r_sb_mask[r_tail] <= dm.dm_wr_mask;
        end
        if (w_drain) begin
            for (int b = 0; b < 4; b++) begin
                if (r_sb_mask[r_head][b])
                    r_mem[r_sb_idx[r_head]][8*b +: 8] <= r_sb_data[r_head][8*b +: 8];
            end
        end
    end

    assign dm.dm_data_in = r_data_in;
    assign dm.dm_stall   = w_stall;
    assign dm.dm_err     = r_err;
endmodule

// File: tb/tb_dmem_store_buf.sv
// Scoreboard bench for dmem_store_buf: load expectations queued at drive time, compared one cycle after acceptance.
// Builds with or without DMEM_SB_FWD_EN; stall expectations follow the macro.
module tb_dmem_store_buf;
`ifdef DMEM_SB_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    dmem_store_buf_if ifc ();

    dmem_store_buf #(.MEM_WORDS(128), .SB_DEPTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .dm  (ifc)
    );

    int          n_chk  = 0;
    int          n_pass = 0;
    logic [31:0] sb_q[$];
    logic [31:0] exp_data = 32'h0;
    bit          pend_ld  = 1'b0;
    bit          pend_err = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    // per-cycle monitor: load data (held between loads) and the error pulse
    initial forever begin
        @(negedge clk);
        if (!rst) begin
            sb_q.delete();
            exp_data = 32'h0;
            pend_ld  = 1'b0;
            pend_err = 1'b0;
            chk("rst_data", ifc.dm_data_in, 32'h0);
            chk("rst_err", {31'b0, ifc.dm_err}, 32'h0);
        end else begin
            if (pend_ld) begin
                if (sb_q.size() == 0) chk("sb_underflow", 32'h1, 32'h0);
                else exp_data = sb_q.pop_front();
            end
            chk("ld_data", ifc.dm_data_in, exp_data);
            chk("err", {31'b0, ifc.dm_err}, {31'b0, pend_err});
            pend_ld  = ifc.dm_rd_req && !ifc.dm_stall;
            pend_err = (ifc.dm_rd_req || ifc.dm_wr_req) && !ifc.dm_stall
                       && (ifc.dm_addr[31:2] >= 30'd128);
        end
    end

    task automatic drive(input bit rd, input bit wr, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] m);
        ifc.dm_rd_req   = rd;
        ifc.dm_wr_req   = wr;
        ifc.dm_addr     = a;
        ifc.dm_data_out = d;
        ifc.dm_wr_mask  = m;
    endtask

    task automatic idle(input int n);
        drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // hold a request until accepted; st_exp < 0 skips the first-cycle stall check
    task automatic xfer(input string tag, input bit rd, input bit wr, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] m, input logic [31:0] exp,
                        input int st_exp);
        bit acc = 1'b0;
        int n   = 0;
        drive(rd, wr, a, d, m);
        if (rd) sb_q.push_back(exp);
        while (!acc && n < 40) begin
            @(negedge clk);
            if (n == 0 && st_exp >= 0) chk({tag, "_stall"}, {31'b0, ifc.dm_stall}, 32'(st_exp));
            acc = !ifc.dm_stall;
            @(posedge clk);
            #1;
            n++;
        end
        if (!acc) chk({tag, "_timeout"}, 32'h1, 32'h0);
        drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    endtask

    // one fixed cycle with a required stall value; queue a load result when one is due
    task automatic cyc(input string tag, input bit rd, input bit wr, input logic [31:0] d,
                       input bit exp_stall, input bit push, input logic [31:0] exp);
        drive(rd, wr, 32'h0, d, 4'hF);
        if (push) sb_q.push_back(exp);
        @(negedge clk);
        chk(tag, {31'b0, ifc.dm_stall}, {31'b0, exp_stall});
        @(posedge clk);
        #1;
    endtask

    initial begin
        drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("rst_stall", {31'b0, ifc.dm_stall}, 32'h0);
        @(posedge clk);
        #1;

        xfer("pre0", 1'b0, 1'b1, 32'h0, 32'hCAFEF00D, 4'hF, 32'h0, 0);
        xfer("pre8", 1'b0, 1'b1, 32'h8, 32'h55667788, 4'hF, 32'h0, -1);
        idle(3);

        xfer("st40", 1'b0, 1'b1, 32'h40, 32'hDEADBEEF, 4'hF, 32'h0, 0);
        xfer("ld40", 1'b1, 1'b0, 32'h40, 32'h0, 4'h0, 32'hDEADBEEF, FWD ? 0 : 1);
        idle(2);
        xfer("ld40_ram", 1'b1, 1'b0, 32'h40, 32'h0, 4'h0, 32'hDEADBEEF, 0);

        // same-cycle load+store sees only older entries; final load merges both
        xfer("mrg1", 1'b1, 1'b1, 32'h8, 32'h11223344, 4'hF, 32'h55667788, 0);
        xfer("mrg2", 1'b1, 1'b1, 32'h8, 32'hAA0000BB, 4'b1001, 32'h11223344, FWD ? 0 : 1);
        xfer("mrg3", 1'b1, 1'b0, 32'h8, 32'h0, 4'h0, 32'hAA2233BB, FWD ? 0 : 1);
        idle(4);

        xfer("oor_st", 1'b0, 1'b1, 32'h200, 32'h12345678, 4'hF, 32'h0, 0);
        xfer("oor_ld", 1'b1, 1'b0, 32'h200, 32'h0, 4'h0, 32'h0, 0);
        xfer("ld0_alias", 1'b1, 1'b0, 32'h0, 32'h0, 4'h0, 32'hCAFEF00D, 0);
        xfer("oor_hi", 1'b1, 1'b0, 32'h8000_0000, 32'h0, 4'h0, 32'h0, 0);
        idle(1);

        xfer("st_top", 1'b0, 1'b1, 32'h1FC, 32'h0BADCAFE, 4'hF, 32'h0, 0);
        xfer("ld_top", 1'b1, 1'b0, 32'h1FC, 32'h0, 4'h0, 32'h0BADCAFE, FWD ? 0 : 1);
        idle(2);

        xfer("st_m0", 1'b0, 1'b1, 32'h40, 32'hFFFFFFFF, 4'h0, 32'h0, 0);
        idle(2);
        xfer("ld_m0", 1'b1, 1'b0, 32'h40, 32'h0, 4'h0, 32'hDEADBEEF, 0);
        idle(2);

`ifdef DMEM_SB_FWD_EN
        cyc("full_c1", 1'b1, 1'b1, 32'hD1D1D1D1, 1'b0, 1'b1, 32'hCAFEF00D);
        cyc("full_c2", 1'b1, 1'b1, 32'hD2D2D2D2, 1'b0, 1'b1, 32'hD1D1D1D1);
        cyc("full_c3", 1'b1, 1'b1, 32'hD3D3D3D3, 1'b0, 1'b1, 32'hD2D2D2D2);
        cyc("full_c4", 1'b1, 1'b1, 32'hD4D4D4D4, 1'b0, 1'b1, 32'hD3D3D3D3);
        cyc("full_c5", 1'b1, 1'b1, 32'hD5D5D5D5, 1'b1, 1'b0, 32'h0);
        cyc("full_drain", 1'b0, 1'b1, 32'hD5D5D5D5, 1'b1, 1'b0, 32'h0);
        cyc("full_accept", 1'b1, 1'b1, 32'hD5D5D5D5, 1'b0, 1'b1, 32'hD4D4D4D4);
        cyc("full_again", 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        idle(6);
        xfer("full_ram", 1'b1, 1'b0, 32'h0, 32'h0, 4'h0, 32'hD5D5D5D5, 0);
        cyc("pend_c1", 1'b1, 1'b1, 32'hE1E1E1E1, 1'b0, 1'b1, 32'hD5D5D5D5);
        cyc("pend_c2", 1'b1, 1'b1, 32'hE2E2E2E2, 1'b0, 1'b1, 32'hE1E1E1E1);
        cyc("pend_c3", 1'b1, 1'b1, 32'hE3E3E3E3, 1'b0, 1'b1, 32'hE2E2E2E2);
        drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        @(negedge clk);
        #1 rst = 1'b0;
`else
        xfer("pend_st", 1'b0, 1'b1, 32'h0, 32'hE1E1E1E1, 4'hF, 32'h0, 0);
        #1 rst = 1'b0;
`endif
        #1;
        chk("rstm_stall", {31'b0, ifc.dm_stall}, 32'h0);
        chk("rstm_data", ifc.dm_data_in, 32'h0);
        chk("rstm_err", {31'b0, ifc.dm_err}, 32'h0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;

        xfer("post_st", 1'b0, 1'b1, 32'h10, 32'h600DF00D, 4'hF, 32'h0, 0);
        xfer("post_ld", 1'b1, 1'b0, 32'h10, 32'h0, 4'h0, 32'h600DF00D, FWD ? 0 : 1);
        idle(3);
        xfer("post_ld2", 1'b1, 1'b0, 32'h10, 32'h0, 4'h0, 32'h600DF00D, 0);
        idle(2);
        chk("sb_left", 32'(sb_q.size()), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
